// File: rtl/tt_slot_if.sv
// Slot sequencer bus: per-slot pin data, core words and frame status.
interface tt_slot_if #(
  parameter int SLOTS = 10,
  parameter int IN_W  = 6,
  parameter int OUT_W = 8
);
  logic                   addr_rst;
  logic                   hold;
  logic                   oneshot;
  logic [IN_W-1:0]        pin_in;
  logic [SLOTS*OUT_W-1:0] core_out;
  logic [OUT_W-1:0]       pin_out;
  logic [SLOTS*IN_W-1:0]  core_in;
  logic [SLOTS-1:0]       slot_sel;
  logic                   frame_start;
  logic                   frame_done;
  logic                   busy;

  modport master (
    output addr_rst, hold, oneshot,
    output pin_in, core_out,
    input  pin_out, core_in, slot_sel,
    input  frame_start, frame_done, busy
  );

  modport slave (
    input  addr_rst, hold, oneshot,
    input  pin_in, core_out,
    output pin_out, core_in, slot_sel,
    output frame_start, frame_done, busy
  );
endinterface

// File: rtl/tt_slot_sequencer.sv
// Time-multiplexed pin sequencer: stages one input word per slot and
// commits a whole frame to the core at once.
module tt_slot_sequencer #(
  parameter int SLOTS = 10,
  parameter int IN_W  = 6,
  parameter int OUT_W = 8
) (
  input  logic     clk,
  input  logic     reset_n,
  tt_slot_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q;
  logic [SLOTS-1:0]      slot_q;
  logic [SLOTS*IN_W-1:0] stage_q;
  logic [SLOTS*IN_W-1:0] stage_nxt;
  logic [SLOTS*IN_W-1:0] core_q;
  logic [OUT_W-1:0]      pin_mux;
  logic                  done_q;
  logic                  advance;
  logic                  last;

  assign advance = (state_q == RUN)
                 && !bus.hold
                 && !bus.addr_rst;
  assign last    = slot_q[SLOTS-1];

  // stage_nxt includes this cycle's capture so the commit sees it
  always_comb begin
    stage_nxt = stage_q;
    pin_mux   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slot_q[i]) begin
        stage_nxt[i*IN_W +: IN_W] = bus.pin_in;
        pin_mux = bus.core_out[i*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      slot_q  <= SLOTS'(1);
      stage_q <= '0;
      core_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        bus.addr_rst: begin
          state_q <= RUN;
          slot_q  <= SLOTS'(1);
          stage_q <= '0;
        end
        advance: begin
          stage_q <= stage_nxt;
          slot_q  <= {slot_q[SLOTS-2:0], slot_q[SLOTS-1]};
          if (last) begin
            core_q <= stage_nxt;
            done_q <= 1'b1;
            if (bus.oneshot) state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pin_out     = pin_mux;
  assign bus.core_in     = core_q;
  assign bus.slot_sel    = slot_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.frame_start = slot_q[0] && (state_q == RUN);
  assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_tt_slot_sequencer.sv
// Directed bench for tt_slot_sequencer: frame timing, hold,
// restart priority, oneshot and asynchronous reset.
module tb_tt_slot_sequencer;
  localparam int S  = 10;
  localparam int IW = 6;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [S*IW-1:0] exp_core;
  logic [S*IW-1:0] prev_core;
  logic [S-1:0]    oh;

  tt_slot_if #(.SLOTS(S), .IN_W(IW), .OUT_W(OW)) bus ();

  tt_slot_sequencer #(.SLOTS(S), .IN_W(IW), .OUT_W(OW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    bus.addr_rst = 1'b1;
    step();
    bus.addr_rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.addr_rst = 1'b0;
    bus.hold     = 1'b0;
    bus.oneshot  = 1'b0;
    bus.pin_in   = '0;
    for (int k = 0; k < S; k++)
      bus.core_out[k*OW +: OW] = 8'(8'hA0 + k);
    reset_n = 1'b0;
    #12;
    checks++;
    if (bus.slot_sel !== 10'h001) begin
      failures++;
      $display("FAIL reset_slot_sel got=%h exp=001", bus.slot_sel);
    end
    checks++;
    if (bus.core_in !== '0) begin
      failures++;
      $display("FAIL reset_core_in got=%h exp=0", bus.core_in);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b exp busy=1 done=0",
               bus.busy, bus.frame_done);
    end
    checks++;
    if (bus.frame_start !== 1'b1) begin
      failures++;
      $display("FAIL reset_frame_start got=%b exp=1", bus.frame_start);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_frame();
    for (int k = 0; k < S; k++) exp_core[k*IW +: IW] = 6'(k);
    for (int i = 0; i < S; i++) begin
      oh = 10'd1 << i;
      checks++;
      if (bus.slot_sel !== oh || bus.pin_out !== 8'(8'hA0 + i)) begin
        failures++;
        $display("FAIL frame_slot%0d sel=%h pin_out=%h exp sel=%h pin_out=%h",
                 i, bus.slot_sel, bus.pin_out, oh, 8'(8'hA0 + i));
      end
      checks++;
      if (bus.frame_start !== (i == 0)) begin
        failures++;
        $display("FAIL frame_start_slot%0d got=%b exp=%b",
                 i, bus.frame_start, (i == 0));
      end
      bus.pin_in = 6'(i);
      step();
      if (i < S - 1) begin
        checks++;
        if (bus.frame_done !== 1'b0 || bus.core_in !== '0) begin
          failures++;
          $display("FAIL frame_early_%0d done=%b core_in=%h exp done=0 core_in=0",
                   i, bus.frame_done, bus.core_in);
        end
      end
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.core_in !== exp_core) begin
      failures++;
      $display("FAIL frame_commit done=%b core_in=%h exp done=1 core_in=%h",
               bus.frame_done, bus.core_in, exp_core);
    end
    checks++;
    if (bus.slot_sel !== 10'h001 || bus.pin_out !== 8'hA0) begin
      failures++;
      $display("FAIL frame_wrap sel=%h pin_out=%h exp sel=001 pin_out=a0",
               bus.slot_sel, bus.pin_out);
    end
    step();
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_width got=%b exp=0", bus.frame_done);
    end
  endtask

  task automatic test_hold();
    prev_core = exp_core;
    for (int k = 0; k < S; k++) exp_core[k*IW +: IW] = 6'(16 + k);
    restart();
    for (int i = 0; i < 4; i++) begin
      bus.pin_in = 6'(16 + i);
      step();
    end
    bus.hold   = 1'b1;
    bus.pin_in = 6'h2A;
    for (int j = 0; j < 5; j++) begin
      step();
      checks++;
      if (bus.slot_sel !== 10'h010 || bus.frame_done !== 1'b0
          || bus.core_in !== prev_core) begin
        failures++;
        $display("FAIL hold_%0d sel=%h done=%b core_in=%h exp sel=010 done=0 core_in=%h",
                 j, bus.slot_sel, bus.frame_done, bus.core_in, prev_core);
      end
    end
    bus.core_out[4*OW +: OW] = 8'h55;
    #1;
    checks++;
    if (bus.pin_out !== 8'h55) begin
      failures++;
      $display("FAIL hold_pin_out got=%h exp=55", bus.pin_out);
    end
    bus.core_out[4*OW +: OW] = 8'hA4;
    bus.hold = 1'b0;
    for (int i = 4; i < S; i++) begin
      bus.pin_in = 6'(16 + i);
      step();
      if (i < S - 1) begin
        checks++;
        if (bus.frame_done !== 1'b0) begin
          failures++;
          $display("FAIL hold_early_done_%0d got=1 exp=0", i);
        end
      end
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.core_in !== exp_core) begin
      failures++;
      $display("FAIL hold_commit done=%b core_in=%h exp done=1 core_in=%h",
               bus.frame_done, bus.core_in, exp_core);
    end
  endtask

  task automatic test_addr_rst_commit();
    restart();
    for (int i = 0; i < S - 1; i++) begin
      bus.pin_in = 6'h05;
      step();
    end
    checks++;
    if (bus.slot_sel !== 10'h200) begin
      failures++;
      $display("FAIL arst_pre_sel got=%h exp=200", bus.slot_sel);
    end
    bus.pin_in   = 6'h3F;
    bus.addr_rst = 1'b1;
    step();
    bus.addr_rst = 1'b0;
    checks++;
    if (bus.frame_done !== 1'b0 || bus.core_in !== exp_core) begin
      failures++;
      $display("FAIL arst_no_commit done=%b core_in=%h exp done=0 core_in=%h",
               bus.frame_done, bus.core_in, exp_core);
    end
    checks++;
    if (bus.slot_sel !== 10'h001 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_sel sel=%h busy=%b exp sel=001 busy=1",
               bus.slot_sel, bus.busy);
    end
    step();
    checks++;
    if (bus.frame_done !== 1'b0 || bus.core_in !== exp_core) begin
      failures++;
      $display("FAIL arst_after done=%b core_in=%h exp done=0 core_in=%h",
               bus.frame_done, bus.core_in, exp_core);
    end
  endtask

  task automatic test_oneshot();
    for (int k = 0; k < S; k++) exp_core[k*IW +: IW] = 6'(9 - k);
    restart();
    bus.oneshot = 1'b1;
    for (int i = 0; i < S; i++) begin
      bus.pin_in = 6'(9 - i);
      step();
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0
        || bus.core_in !== exp_core) begin
      failures++;
      $display("FAIL oneshot_commit done=%b busy=%b core_in=%h exp 1 0 %h",
               bus.frame_done, bus.busy, bus.core_in, exp_core);
    end
    checks++;
    if (bus.slot_sel !== 10'h001 || bus.frame_start !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_park sel=%h fstart=%b exp sel=001 fstart=0",
               bus.slot_sel, bus.frame_start);
    end
    for (int j = 0; j < 20; j++) begin
      bus.pin_in = 6'(j);
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.slot_sel !== 10'h001
          || bus.frame_done !== 1'b0 || bus.core_in !== exp_core) begin
        failures++;
        $display("FAIL oneshot_idle_%0d busy=%b sel=%h done=%b core_in=%h exp 0 001 0 %h",
                 j, bus.busy, bus.slot_sel, bus.frame_done, bus.core_in, exp_core);
      end
    end
    restart();
    checks++;
    if (bus.busy !== 1'b1 || bus.frame_start !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_restart busy=%b fstart=%b exp 1 1",
               bus.busy, bus.frame_start);
    end
    for (int k = 0; k < S; k++) exp_core[k*IW +: IW] = 6'(32 + k);
    for (int i = 0; i < S; i++) begin
      if (i == 5) bus.oneshot = 1'b0;
      bus.pin_in = 6'(32 + i);
      step();
    end
    checks++;
    if (bus.frame_done !== 1'b1 || bus.busy !== 1'b1
        || bus.core_in !== exp_core) begin
      failures++;
      $display("FAIL oneshot_clear done=%b busy=%b core_in=%h exp 1 1 %h",
               bus.frame_done, bus.busy, bus.core_in, exp_core);
    end
    step();
    checks++;
    if (bus.slot_sel !== 10'h002 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_rerun sel=%h busy=%b exp sel=002 busy=1",
               bus.slot_sel, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int i = 0; i < 6; i++) begin
      bus.pin_in = 6'h07;
      step();
    end
    checks++;
    if (bus.slot_sel !== 10'h040) begin
      failures++;
      $display("FAIL ares_pre_sel got=%h exp=040", bus.slot_sel);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.slot_sel !== 10'h001 || bus.core_in !== '0
        || bus.busy !== 1'b1 || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL ares_async sel=%h core_in=%h busy=%b done=%b exp 001 0 1 0",
               bus.slot_sel, bus.core_in, bus.busy, bus.frame_done);
    end
    @(negedge clk);
    reset_n    = 1'b1;
    bus.pin_in = 6'h11;
    step();
    checks++;
    if (bus.slot_sel !== 10'h002 || bus.core_in !== '0
        || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL ares_first_adv sel=%h core_in=%h done=%b exp 002 0 0",
               bus.slot_sel, bus.core_in, bus.frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_hold();
    test_addr_rst_commit();
    test_oneshot();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
